// File: rtl/io_frame_pkg.sv
// Shared types and constants for the UART-to-compute frame controller.
package io_frame_pkg;

    localparam int ByteWidth = 8;

    typedef enum logic [1:0] {
        RX_COLLECT = 2'd0,
        IN_HANDOFF = 2'd1,
        OUT_WAIT   = 2'd2,
        TX_SEND    = 2'd3
    } frame_state_e;

    // Lane counter must address the larger of the two frames, never narrower than one bit.
    function automatic int count_width(input int in_bytes, input int out_bytes);
        int max_bytes;
        if (in_bytes > out_bytes) begin
            max_bytes = in_bytes;
        end else begin
            max_bytes = out_bytes;
        end
        if (max_bytes > 32'sd1) begin
            return $clog2(max_bytes);
        end else begin
            return 32'sd1;
        end
    endfunction

endpackage

// File: rtl/io_frame_controller.sv
// Collects UART bytes into a compute operand, hands it off, then streams the
// compute result back out to the UART transmitter one byte at a time, LSB first.
module io_frame_controller
    import io_frame_pkg::*;
#(
    parameter int InputBytes  = 1,
    parameter int OutputBytes = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ByteWidth-1:0]            rx_byte,
    input  logic                            rx_byte_valid,
    output logic                            rx_byte_done,
    output logic [ByteWidth-1:0]            tx_byte,
    output logic                            tx_byte_valid,
    input  logic                            tx_byte_done,
    output logic [InputBytes*ByteWidth-1:0] flat_input,
    output logic                            flat_input_valid,
    input  logic                            flat_input_ready,
    input  logic [OutputBytes*ByteWidth-1:0] flat_output,
    input  logic                            flat_output_valid,
    output logic                            flat_output_ready,
    output logic                            clear_to_send_out_n
);

    localparam int CountW = count_width(InputBytes, OutputBytes);
    localparam logic [CountW-1:0] CountZero = CountW'(0);
    localparam logic [CountW-1:0] CountOne  = CountW'(1);
    localparam logic [CountW-1:0] InLast    = CountW'(InputBytes - 1);
    localparam logic [CountW-1:0] OutLast   = CountW'(OutputBytes - 1);

    frame_state_e                     state_r;
    frame_state_e                     state_nxt_s;
    logic [CountW-1:0]                byte_count_r;
    logic [CountW-1:0]                byte_count_nxt_s;
    logic [InputBytes*ByteWidth-1:0]  flat_input_r;
    logic [OutputBytes*ByteWidth-1:0] result_r;
    logic [ByteWidth-1:0]             tx_byte_r;
    logic                             rx_byte_done_r;
    logic                             tx_byte_valid_r;
    logic                             flat_input_valid_r;
    logic                             flat_output_ready_r;
    logic                             cts_n_r;

    logic rx_capture_s;
    logic in_accept_s;
    logic out_accept_s;
    logic tx_accept_s;
    logic tx_last_s;

    // Handshake qualifiers; the done register blocks re-capturing the byte just acknowledged.
    always_comb begin
        rx_capture_s = (state_r == RX_COLLECT) && rx_byte_valid && !rx_byte_done_r;
        in_accept_s  = (state_r == IN_HANDOFF) && flat_input_ready;
        out_accept_s = (state_r == OUT_WAIT) && flat_output_valid;
        tx_accept_s  = (state_r == TX_SEND) && tx_byte_valid_r && tx_byte_done;
        tx_last_s    = (byte_count_r == OutLast);
    end

    // Next-state and lane counter sequencing.
    always_comb begin
        state_nxt_s      = state_r;
        byte_count_nxt_s = byte_count_r;
        case (state_r)
            RX_COLLECT: begin
                if (rx_capture_s) begin
                    if (byte_count_r == InLast) begin
                        byte_count_nxt_s = CountZero;
                        state_nxt_s      = IN_HANDOFF;
                    end else begin
                        byte_count_nxt_s = byte_count_r + CountOne;
                        state_nxt_s      = RX_COLLECT;
                    end
                end else begin
                    byte_count_nxt_s = byte_count_r;
                    state_nxt_s      = RX_COLLECT;
                end
            end
            IN_HANDOFF: begin
                if (in_accept_s) begin
                    state_nxt_s = OUT_WAIT;
                end else begin
                    state_nxt_s = IN_HANDOFF;
                end
            end
            OUT_WAIT: begin
                if (out_accept_s) begin
                    state_nxt_s = TX_SEND;
                end else begin
                    state_nxt_s = OUT_WAIT;
                end
            end
            TX_SEND: begin
                if (tx_accept_s) begin
                    if (tx_last_s) begin
                        byte_count_nxt_s = CountZero;
                        state_nxt_s      = RX_COLLECT;
                    end else begin
                        byte_count_nxt_s = byte_count_r + CountOne;
                        state_nxt_s      = TX_SEND;
                    end
                end else begin
                    byte_count_nxt_s = byte_count_r;
                    state_nxt_s      = TX_SEND;
                end
            end
            default: begin
                state_nxt_s      = RX_COLLECT;
                byte_count_nxt_s = CountZero;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RX_COLLECT;
            byte_count_r <= CountZero;
        end else begin
            state_r      <= state_nxt_s;
            byte_count_r <= byte_count_nxt_s;
        end
    end

    // Operand assembly: each captured byte lands in the lane selected by the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_input_r   <= '0;
            rx_byte_done_r <= 1'b0;
        end else begin
            rx_byte_done_r <= rx_capture_s;
            if (rx_capture_s) begin
                flat_input_r[int'(byte_count_r)*ByteWidth +: ByteWidth] <= rx_byte;
            end
        end
    end

    // Result capture and outgoing byte selection; the next lane is staged on each accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r  <= '0;
            tx_byte_r <= '0;
        end else begin
            if (out_accept_s) begin
                result_r  <= flat_output;
                tx_byte_r <= flat_output[ByteWidth-1:0];
            end else if (tx_accept_s && !tx_last_s) begin
                tx_byte_r <= result_r[int'(byte_count_nxt_s)*ByteWidth +: ByteWidth];
            end
        end
    end

    // Handshake flags decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_valid_r     <= 1'b0;
            flat_input_valid_r  <= 1'b0;
            flat_output_ready_r <= 1'b0;
            cts_n_r             <= 1'b0;
        end else begin
            tx_byte_valid_r     <= (state_nxt_s == TX_SEND);
            flat_input_valid_r  <= (state_nxt_s == IN_HANDOFF);
            flat_output_ready_r <= (state_nxt_s == OUT_WAIT);
            cts_n_r             <= (state_nxt_s != RX_COLLECT);
        end
    end

    assign rx_byte_done      = rx_byte_done_r;
    assign tx_byte           = tx_byte_r;
    assign tx_byte_valid     = tx_byte_valid_r;
    assign flat_input        = flat_input_r;
    assign flat_input_valid  = flat_input_valid_r;
    assign flat_output_ready = flat_output_ready_r;
    // Host is told to hold off while the block itself is held in reset.
    assign clear_to_send_out_n = cts_n_r | ~rst_n;

endmodule

// File: doc/io_frame_controller.md
IO_FRAME_CONTROLLER -- requirements
Module: io_frame_controller

Interface
REQ-001 SHALL have parameter InputBytes, default 1: bytes per compute input frame (>=1).
REQ-002 SHALL have parameter OutputBytes, default 1: bytes per compute output frame (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-006 SHALL have port rx_byte_valid  input  1  receiver holds rx_byte valid until acknowledged.
REQ-007 SHALL have port rx_byte_done  output  1  one-cycle acknowledge that rx_byte was captured.
REQ-008 SHALL have port tx_byte  output  8  byte to UART transmitter.
REQ-009 SHALL have port tx_byte_valid  output  1  tx_byte is offered.
REQ-010 SHALL have port tx_byte_done  input  1  transmitter accepted tx_byte this cycle.
REQ-011 SHALL have port flat_input  output  InputBytes*8  assembled compute operand.
REQ-012 SHALL have port flat_input_valid / flat_input_ready  output / input  1 each  operand handshake.
REQ-013 SHALL have port flat_output  input  OutputBytes*8  compute result.
REQ-014 SHALL have port flat_output_valid / flat_output_ready  input / output  1 each  result handshake.
REQ-015 SHALL have port clear_to_send_out_n  output  1  active-low: host may send bytes.

Function
REQ-016 SHALL implement states RX_COLLECT, IN_HANDOFF, OUT_WAIT, TX_SEND; reset state RX_COLLECT.
REQ-017 In RX_COLLECT with rx_byte_valid=1, SHALL write rx_byte into byte lane byte_count of flat_input (first byte -> bits [7:0]), pulse rx_byte_done for exactly that cycle, increment byte_count.
REQ-018 SHALL never assert rx_byte_done on consecutive cycles; a byte still valid the cycle after done is a new byte.
REQ-019 On capture of byte InputBytes-1, SHALL clear byte_count to 0 and enter IN_HANDOFF next cycle (no wrap beyond InputBytes-1).
REQ-020 clear_to_send_out_n SHALL be 0 only in RX_COLLECT; SHALL be 1 from the cycle after the last input byte is captured until return to RX_COLLECT.
REQ-021 rx_byte_valid outside RX_COLLECT SHALL be ignored: no capture, rx_byte_done=0.
REQ-022 flat_input_valid SHALL be 1 exactly in IN_HANDOFF; flat_input SHALL be stable there; flat_input_valid&flat_input_ready -> OUT_WAIT next cycle.
REQ-023 flat_output_ready SHALL be 1 exactly in OUT_WAIT; on flat_output_valid=1 SHALL latch flat_output into an internal shift register and enter TX_SEND next cycle.
REQ-024 In TX_SEND, tx_byte SHALL be byte lane byte_count of the latched result (LSB byte first), tx_byte_valid=1, stable until tx_byte_done=1 at a clock edge.
REQ-025 On tx_byte_done with byte_count=OutputBytes-1, SHALL clear byte_count and return to RX_COLLECT next cycle; otherwise increment byte_count.
REQ-026 tx_byte_done while tx_byte_valid=0 SHALL be ignored.
REQ-027 byte_count width SHALL be max(1, clog2(max(InputBytes,OutputBytes))).
REQ-028 Minimum frame turnaround with zero-wait partners: 1 cycle IN_HANDOFF + 1 cycle OUT_WAIT + OutputBytes TX handshakes.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force: state RX_COLLECT, byte_count 0, flat_input 0, result register 0, rx_byte_done 0, tx_byte_valid 0, flat_input_valid 0, flat_output_ready 0, tx_byte 0, clear_to_send_out_n 0 once out of reset (1 while rst_n=0).
REQ-030 Reset mid-frame (any state) SHALL discard partial input/output; first post-reset byte lands in lane 0.
REQ-031 Reset release SHALL be synchronised by the surrounding reset logic; the block assumes deassertion meets recovery timing.

Structure
REQ-032 Shared package io_frame_pkg SHALL hold the state enum and ByteWidth=8 constant.
REQ-033 No sub-module; byte lane select/insert SHALL be inline indexed part-selects.

Verification
REQ-034 In=1,Out=1: rx 0x55 -> rx_byte_done one pulse, flat_input=0x55 valid; return result 0x56 -> tx_byte=0x56 offered, cts_n=0 after tx_byte_done.
REQ-035 In=2,Out=2: rx 0x34 then 0x12 -> flat_input=0x1234; result 0xBEEF -> tx 0xEF then 0xBE.
REQ-036 flat_input_ready held 0 for 5 cycles -> flat_input_valid stays 1, flat_input unchanged, cts_n=1 throughout.
REQ-037 tx_byte_done delayed 7 cycles -> tx_byte/tx_byte_valid stable 7 cycles; rx_byte_valid=1 with 0xAA during TX_SEND -> no rx_byte_done, not captured.
REQ-038 rst_n pulsed low in TX_SEND -> tx_byte_valid=0 same cycle; next frame rx 0x01 -> flat_input=0x01 in lane 0.
